// File: rtl/pulse_pkg.sv
// Shared types and constants for the pulse stretcher.
package pulse_pkg;

    // FSM state encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    // All-ones value of a w-bit counter, used as the saturation ceiling
    function automatic logic [31:0] sat_max(input int unsigned w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/pulse_down_cnt.sv
// Loadable down-counter shared by the HOLD and GAP phases.
module pulse_down_cnt #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LEN_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [LEN_W-1:0] cnt;

    // Load has priority over decrement; never wraps below zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_stretch.sv
// Stretches single-cycle triggers into programmable-length levels with
// an enforced low gap; triggers that cannot be honoured are counted.
module pulse_stretch
    import pulse_pkg::*;
#(
    parameter int LEN_W      = 8,
    parameter int GAP_CYCLES = 2,
    parameter int RETRIGGER  = 0,
    parameter int MISS_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trigger,
    input  logic [LEN_W-1:0]  length,
    output logic              level,
    output logic              busy,
    output logic              missed,
    output logic [MISS_W-1:0] miss_cnt
);

    localparam logic [LEN_W-1:0]  GAP_M1   = (GAP_CYCLES > 0) ? LEN_W'(GAP_CYCLES - 1) : '0;
    localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(sat_max(MISS_W));
    localparam bit                RETRIG   = (RETRIGGER != 0);
    localparam bit                HAS_GAP  = (GAP_CYCLES > 0);

    state_t           state;
    logic             zero;
    logic             load;
    logic             dec;
    logic             drop;
    logic [LEN_W-1:0] load_val;
    logic [LEN_W-1:0] len_m1;

    // A zero length behaves like one cycle
    assign len_m1 = (length == '0) ? '0 : (length - 1'b1);

    // Counter control and drop decision for the current cycle
    always_comb begin
        load     = 1'b0;
        load_val = len_m1;
        dec      = 1'b0;
        drop     = 1'b0;
        case (state)
            IDLE: load = trigger;
            HOLD: begin
                if (trigger && RETRIG) begin
                    load = 1'b1;
                end else begin
                    drop = trigger;
                    if (zero) begin
                        load     = HAS_GAP;
                        load_val = GAP_M1;
                    end else begin
                        dec = 1'b1;
                    end
                end
            end
            GAP: begin
                drop = trigger;
                dec  = !zero;
            end
            default: ;
        endcase
    end

    pulse_down_cnt #(.LEN_W(LEN_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .dec      (dec),
        .zero     (zero)
    );

    // FSM with registered level/busy, plus the drop flag and saturating counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            level    <= 1'b0;
            busy     <= 1'b0;
            missed   <= 1'b0;
            miss_cnt <= '0;
        end else begin
            missed <= drop;
            if (drop && miss_cnt != MISS_MAX)
                miss_cnt <= miss_cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state <= HOLD;
                        level <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                HOLD: begin
                    // a reload keeps us in HOLD even on the last cycle
                    if (!(trigger && RETRIG) && zero) begin
                        level <= 1'b0;
                        if (HAS_GAP) begin
                            state <= GAP;
                            busy  <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (zero) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    level <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_stretch.sv
// Three configurations driven by shared stimulus, each compared per cycle
// against a remaining-cycles reference model.
module tb_pulse_stretch;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       trig = 1'b0;
    logic [7:0] len = 8'd0;

    logic [2:0] lvl, bsy, mis;
    logic [7:0] mc_a, mc_b;
    logic [1:0] mc_c;

    int n_vec = 0;
    int n_err = 0;

    // model configuration per DUT: A default, B retrigger, C no gap + 2-bit counter
    int cfg_gap  [3] = '{2, 2, 0};
    int cfg_rt   [3] = '{0, 1, 0};
    int cfg_mmax [3] = '{255, 255, 3};

    // model state: cycles of high still to come, gap cycles still to come
    int h [3];
    int g [3];
    int m_missed [3];
    int m_cnt [3];

    always #5 clk = ~clk;

    pulse_stretch #(.LEN_W(8), .GAP_CYCLES(2), .RETRIGGER(0), .MISS_W(8)) dut_a (
        .clk(clk), .rst(rst), .trigger(trig), .length(len),
        .level(lvl[0]), .busy(bsy[0]), .missed(mis[0]), .miss_cnt(mc_a));

    pulse_stretch #(.LEN_W(8), .GAP_CYCLES(2), .RETRIGGER(1), .MISS_W(8)) dut_b (
        .clk(clk), .rst(rst), .trigger(trig), .length(len),
        .level(lvl[1]), .busy(bsy[1]), .missed(mis[1]), .miss_cnt(mc_b));

    pulse_stretch #(.LEN_W(8), .GAP_CYCLES(0), .RETRIGGER(0), .MISS_W(2)) dut_c (
        .clk(clk), .rst(rst), .trigger(trig), .length(len),
        .level(lvl[2]), .busy(bsy[2]), .missed(mis[2]), .miss_cnt(mc_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] mc_of(input int i);
        case (i)
            0:       return 32'(mc_a);
            1:       return 32'(mc_b);
            default: return 32'(mc_c);
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            h[i] = 0; g[i] = 0; m_missed[i] = 0; m_cnt[i] = 0;
        end
    endtask

    // one clock edge of the reference behaviour
    task automatic model_step(input logic t, input logic [7:0] l);
        int lv;
        lv = (l == 0) ? 1 : int'(l);
        for (int i = 0; i < 3; i++) begin
            bit taken;
            taken = 1'b0;
            m_missed[i] = 0;
            if (t) begin
                if (h[i] == 0 && g[i] == 0) taken = 1'b1;
                else if (h[i] > 0 && cfg_rt[i] != 0) taken = 1'b1;
                else begin
                    m_missed[i] = 1;
                    if (m_cnt[i] < cfg_mmax[i]) m_cnt[i]++;
                end
            end
            if (taken) begin
                h[i] = lv;
            end else if (h[i] > 0) begin
                h[i]--;
                if (h[i] == 0) g[i] = cfg_gap[i];
            end else if (g[i] > 0) begin
                g[i]--;
            end
        end
    endtask

    task automatic check_all(input string phase);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s dut%0d level", phase, i), 32'(lvl[i]), 32'(h[i] > 0));
            chk($sformatf("%s dut%0d busy", phase, i), 32'(bsy[i]), 32'(h[i] > 0 || g[i] > 0));
            chk($sformatf("%s dut%0d missed", phase, i), 32'(mis[i]), 32'(m_missed[i]));
            chk($sformatf("%s dut%0d miss_cnt", phase, i), mc_of(i), 32'(m_cnt[i]));
        end
    endtask

    // apply current inputs for one edge, then compare
    task automatic cycle(input string phase);
        @(posedge clk);
        if (rst) model_reset();
        else model_step(trig, len);
        #1;
        check_all(phase);
    endtask

    task automatic idle(input int n, input string phase);
        trig = 1'b0;
        for (int k = 0; k < n; k++) cycle(phase);
    endtask

    task automatic pulse(input logic [7:0] l, input string phase);
        trig = 1'b1;
        len  = l;
        cycle(phase);
        trig = 1'b0;
        len  = $urandom_range(0, 255);   // ignored until next accept
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        #1;
        check_all("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        idle(9, "pre");
        pulse(8'd5, "len5");
        idle(10, "len5");

        pulse(8'd0, "len0");
        idle(5, "len0");

        pulse(8'd6, "drop");
        idle(2, "drop");
        pulse(8'd6, "drop");
        idle(3, "drop");
        pulse(8'd6, "drop");
        idle(10, "drop");

        pulse(8'd4, "retrig");
        idle(2, "retrig");
        pulse(8'd3, "retrig");
        idle(10, "retrig");

        pulse(8'd3, "merge");
        idle(2, "merge");
        pulse(8'd3, "merge");
        idle(10, "merge");

        // held trigger: one decision per cycle, saturates the 2-bit counter
        trig = 1'b1;
        len  = 8'd7;
        for (int k = 0; k < 9; k++) cycle("held");
        idle(12, "held");

        // asynchronous reset in the middle of HOLD
        pulse(8'd8, "arst");
        idle(2, "arst");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("arst_async");
        cycle("arst_hold");
        rst = 1'b0;
        idle(2, "arst_rel");
        pulse(8'd4, "arst_rel");
        idle(8, "arst_rel");

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            trig = ($urandom_range(0, 99) < 30);
            len  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 7));
            cycle("rand");
        end
        idle(60, "drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
